// File: rtl/byte_enable_ram_if.sv
// Bus bundle for byte_enable_ram: write data, address, write/byte-lane
// enables going in, registered read data and address echo coming out.
interface byte_enable_ram_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic                  byteena;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ADDR_WIDTH-1:0] addr_out;

    modport master (
        output data_in, addr, we, byteena,
        input  data_out, addr_out
    );

    modport slave (
        input  data_in, addr, we, byteena,
        output data_out, addr_out
    );
endinterface

// File: rtl/byte_enable_ram.sv
// byte_enable_ram: single-port 2**ADDR_WIDTH x DATA_WIDTH scratch RAM.
// byteena=0 writes the whole word, byteena=1 writes only the high byte.
// Read data and the address echo are registered (1-cycle latency) and
// refresh every non-reset cycle. Same-address read-during-write is
// read-first by default; define RAM_WRITE_THROUGH_EN to return the newly
// written (merged) word instead. Reset clears only the output registers.
// DATA_WIDTH must be even (two byte lanes).
module byte_enable_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    byte_enable_ram_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int HALF  = DATA_WIDTH / 2;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [ADDR_WIDTH-1:0] addr_out_q;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] wr_word;

    assign rd_word = mem_q[bus.addr];

    // Word that the addressed location holds after this edge's write:
    // a high-byte write keeps the stored low byte.
    always_comb begin
        wr_word = bus.data_in;
        if (bus.byteena)
            wr_word = {bus.data_in[DATA_WIDTH-1:HALF], rd_word[HALF-1:0]};
    end

    // Read-port source: stored word, or the merged write word when forwarding.
    always_comb begin
        data_out_d = rd_word;
`ifdef RAM_WRITE_THROUGH_EN
        if (bus.we)
            data_out_d = wr_word;
`endif
    end

    // Storage: no reset on the array; reset blocks writes.
    always_ff @(posedge clk) begin
        if (!rst && bus.we)
            mem_q[bus.addr] <= wr_word;
    end

    // Output registers: cleared by reset, otherwise follow the access.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
            addr_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
            addr_out_q <= bus.addr;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.addr_out = addr_out_q;
endmodule

// File: tb/tb_byte_enable_ram.sv
// Self-checking bench for byte_enable_ram: directed plan steps followed by
// randomized traffic, all checked against a word-array reference model.
module tb_byte_enable_ram;
    logic clk = 1'b0;
    logic rst;

    byte_enable_ram_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

    byte_enable_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: contents plus per-byte "has been written" flags.
    logic [15:0] ref_mem [256];
    bit          kn_hi   [256];
    bit          kn_lo   [256];

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock of traffic: drive, clock, check outputs against model, update model.
    task automatic cyc(input string tag, input bit r, input bit w, input bit be,
                       input logic [7:0] a, input logic [15:0] d);
        logic [15:0] old, nw, exp_d;
        bit          old_kn, new_kn, exp_kn;
        rst         = r;
        bus.we      = w;
        bus.byteena = be;
        bus.addr    = a;
        bus.data_in = d;
        old    = ref_mem[a];
        old_kn = kn_hi[a] && kn_lo[a];
        nw     = be ? ((d & 16'hFF00) | (old & 16'h00FF)) : d;
        new_kn = be ? kn_lo[a] : 1'b1;
        exp_d  = old;
        exp_kn = old_kn;
`ifdef RAM_WRITE_THROUGH_EN
        if (w) begin
            exp_d  = nw;
            exp_kn = new_kn;
        end
`endif
        @(posedge clk);
        #1;
        if (r) begin
            chk({tag, ".rst_dout"}, {16'h0, bus.data_out}, 32'h0);
            chk({tag, ".rst_aout"}, {24'h0, bus.addr_out}, 32'h0);
        end else begin
            chk({tag, ".aout"}, {24'h0, bus.addr_out}, {24'h0, a});
            if (exp_kn)
                chk({tag, ".dout"}, {16'h0, bus.data_out}, {16'h0, exp_d});
            if (w) begin
                ref_mem[a] = nw;
                kn_hi[a]   = 1'b1;
                kn_lo[a]   = new_kn;
            end
        end
    endtask

    initial begin
        logic [15:0] v;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 16'h0;
            kn_hi[i]   = 1'b0;
            kn_lo[i]   = 1'b0;
        end
        rst = 1'b1; bus.we = 1'b0; bus.byteena = 1'b0; bus.addr = '0; bus.data_in = '0;

        // 1: reset with a nonzero address on the bus
        cyc("reset", 1, 0, 0, 8'h05, 16'h0);
        cyc("reset", 1, 0, 0, 8'h05, 16'h0);

        // 2: word writes then readback
        for (int i = 0; i < 8; i++) begin
            v = 16'(32'h2000 * (i + 1));
            cyc("wword", 0, 1, 0, 8'(i), v);
        end
        for (int i = 0; i < 8; i++) cyc("rword", 0, 0, 0, 8'(i), 16'h0);
        chk("rword.a7", {16'h0, ref_mem[7]}, 32'h0000);

        // 3: high-byte writes keep the stored low byte
        for (int i = 0; i < 8; i++) begin
            v = 16'(32'h0800 * (i + 1) + 32'h00FF);
            cyc("whigh", 0, 1, 1, 8'(i), v);
        end
        for (int i = 0; i < 8; i++) cyc("rhigh", 0, 0, 0, 8'(i), 16'h0);

        // 4: read-during-write on the same address
        cyc("rdw.pre", 0, 1, 0, 8'h03, 16'hAAAA);
        cyc("rdw.wr",  0, 1, 0, 8'h03, 16'h5555);
        cyc("rdw.rd",  0, 0, 0, 8'h03, 16'h0);

        // 5: we=0 with byteena toggling must not disturb contents
        for (int i = 0; i < 8; i++) cyc("nowe", 0, 0, 1'(i), 8'(i), 16'hFFFF);
        for (int i = 0; i < 8; i++) cyc("nowe.rd", 0, 0, 0, 8'(i), 16'h0);

        // 6: reset beats a simultaneous write
        cyc("rprio.pre", 0, 1, 0, 8'hFF, 16'hBEEF);
        cyc("rprio.rst", 1, 1, 0, 8'hFF, 16'h1234);
        cyc("rprio.rd",  0, 0, 0, 8'hFF, 16'h0);
        cyc("rprio.rd0", 0, 0, 0, 8'h00, 16'h0);

        // Random traffic concentrated on a few addresses to force collisions
        for (int n = 0; n < 600; n++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            cyc("rand", ($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, a, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
